// File: rtl/text_console_pkg.sv
// Shared constants for the text console: default screen geometry (also used by
// the pixel generator), control-code byte values and the writer FSM states.
package text_console_pkg;

  localparam int TEXT_WIDTH  = 60;
  localparam int TEXT_HEIGHT = 20;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLR_LINE = 2'd1,
    S_CLR_ALL  = 2'd2
  } console_state_t;

endpackage

// File: rtl/text_cursor_ctr.sv
// Cursor counter for the text console. Tracks column, row and the linear base
// address of the current row (stepped by TEXT_WIDTH, so no multiplier), and
// presents the linear RAM address of the cursor cell.
// Operation priority: home > line advance (explicit or column wrap) > inc >
// dec > cr.
module text_cursor_ctr #(
  parameter int TEXT_WIDTH  = text_console_pkg::TEXT_WIDTH,
  parameter int TEXT_HEIGHT = text_console_pkg::TEXT_HEIGHT,
  parameter int ADDR_W      = 13
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           op_inc,
  input  logic                           op_dec,
  input  logic                           op_cr,
  input  logic                           op_adv,
  input  logic                           op_home,
  output logic [$clog2(TEXT_WIDTH)-1:0]  col,
  output logic [$clog2(TEXT_HEIGHT)-1:0] row,
  output logic [ADDR_W-1:0]              row_base,
  output logic [ADDR_W-1:0]              addr,
  output logic                           at_eol
);

  localparam int COL_W = $clog2(TEXT_WIDTH);
  localparam int ROW_W = $clog2(TEXT_HEIGHT);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;

  assign at_eol   = (col_q == COL_W'(TEXT_WIDTH - 1));
  assign col      = col_q;
  assign row      = row_q;
  assign row_base = base_q;
  assign addr     = base_q + ADDR_W'(col_q);

  // Next cursor position from the requested operation.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (op_home) begin
      col_d  = '0;
      row_d  = '0;
      base_d = '0;
    end else if (op_adv || (op_inc && at_eol)) begin
      col_d = '0;
      if (row_q == ROW_W'(TEXT_HEIGHT - 1)) begin
        row_d  = '0;
        base_d = '0;
      end else begin
        row_d  = row_q + 1'b1;
        base_d = base_q + ADDR_W'(TEXT_WIDTH);
      end
    end else if (op_inc) begin
      col_d = col_q + 1'b1;
    end else if (op_dec) begin
      if (col_q != '0) col_d = col_q - 1'b1;
    end else if (op_cr) begin
      col_d = '0;
    end
  end

  // Cursor state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Text console writer: turns a valid/ready byte stream into writes on the text
// RAM write port. Glyphs are written at the cursor; a line advance clears the
// new row; form feed clears the whole screen. While a clear runs the input is
// stalled (in_ready low).
// Optional feature macro: TEXT_CTRL_CODES_EN enables CR/LF/BS/FF handling;
// without it every byte is a glyph and only column wrap advances the line.
module text_console_writer #(
  parameter int         TEXT_WIDTH  = text_console_pkg::TEXT_WIDTH,
  parameter int         TEXT_HEIGHT = text_console_pkg::TEXT_HEIGHT,
  parameter int         TEXT_LEN    = TEXT_WIDTH * TEXT_HEIGHT,
  parameter int         ADDR_W      = 13,
  parameter logic [7:0] FILL_CHAR   = 8'h20
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_data,
  output logic                           text_wr_ena,
  output logic [7:0]                     text_wr_data,
  output logic [ADDR_W-1:0]              text_wr_addr,
  output logic [$clog2(TEXT_WIDTH)-1:0]  cursor_col,
  output logic [$clog2(TEXT_HEIGHT)-1:0] cursor_row,
  output logic                           busy
);

  import text_console_pkg::*;

  // One extra bit so the clear counter can reach TEXT_LEN even when it fills
  // the whole address space.
  localparam int CNT_W = ADDR_W + 1;

  console_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_ena_q, wr_ena_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              accept, do_glyph;
  logic              op_inc, op_dec, op_cr, op_adv, op_home;
  logic [ADDR_W-1:0] cur_addr, row_base;
  logic              at_eol;

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign accept       = in_valid && in_ready;
  assign text_wr_ena  = wr_ena_q;
  assign text_wr_data = wr_data_q;
  assign text_wr_addr = wr_addr_q;

  text_cursor_ctr #(
    .TEXT_WIDTH (TEXT_WIDTH),
    .TEXT_HEIGHT(TEXT_HEIGHT),
    .ADDR_W     (ADDR_W)
  ) u_cursor (
    .clk     (clk),
    .reset_n (reset_n),
    .op_inc  (op_inc),
    .op_dec  (op_dec),
    .op_cr   (op_cr),
    .op_adv  (op_adv),
    .op_home (op_home),
    .col     (cursor_col),
    .row     (cursor_row),
    .row_base(row_base),
    .addr    (cur_addr),
    .at_eol  (at_eol)
  );

  // Byte decode, clear sequencing and next write-port values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ena_d  = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    op_inc    = 1'b0;
    op_dec    = 1'b0;
    op_cr     = 1'b0;
    op_adv    = 1'b0;
    op_home   = 1'b0;
    do_glyph  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          do_glyph = 1'b1;
`ifdef TEXT_CTRL_CODES_EN
          case (in_data)
            CC_CR: begin
              do_glyph = 1'b0;
              op_cr    = 1'b1;
            end
            CC_BS: begin
              do_glyph = 1'b0;
              op_dec   = 1'b1;
            end
            CC_LF: begin
              do_glyph = 1'b0;
              op_adv   = 1'b1;
              state_d  = S_CLR_LINE;
              cnt_d    = '0;
            end
            CC_FF: begin
              do_glyph = 1'b0;
              op_home  = 1'b1;
              state_d  = S_CLR_ALL;
              cnt_d    = '0;
            end
            default: ;
          endcase
`endif
          if (do_glyph) begin
            wr_ena_d  = 1'b1;
            wr_data_d = in_data;
            wr_addr_d = cur_addr;
            op_inc    = 1'b1;
            // Writing the last column wraps; the new row gets cleared.
            if (at_eol) begin
              state_d = S_CLR_LINE;
              cnt_d   = '0;
            end
          end
        end
      end
      // row_base already points at the new row when this state is entered.
      S_CLR_LINE: begin
        if (cnt_q == CNT_W'(TEXT_WIDTH)) begin
          state_d = S_IDLE;
        end else begin
          wr_ena_d  = 1'b1;
          wr_data_d = FILL_CHAR;
          wr_addr_d = row_base + ADDR_W'(cnt_q);
          cnt_d     = cnt_q + 1'b1;
        end
      end
`ifdef TEXT_CTRL_CODES_EN
      S_CLR_ALL: begin
        if (cnt_q == CNT_W'(TEXT_LEN)) begin
          state_d = S_IDLE;
        end else begin
          wr_ena_d  = 1'b1;
          wr_data_d = FILL_CHAR;
          wr_addr_d = ADDR_W'(cnt_q);
          cnt_d     = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, clear counter and registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_ena_q  <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ena_q  <= wr_ena_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer. A negedge monitor shadows the RAM
// and counts writes per address; the directed steps compare against constants.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        text_wr_ena;
  logic [7:0]  text_wr_data;
  logic [12:0] text_wr_addr;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  logic [7:0] mem  [0:8191];
  int         hits [0:8191];
  int         hsnap[0:1199];
  int         wr_cnt = 0;
  int         bad_addr = 0;

  text_console_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .text_wr_ena (text_wr_ena),
    .text_wr_data(text_wr_data),
    .text_wr_addr(text_wr_addr),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Shadow RAM written at the negedge, away from the active edge.
  always @(negedge clk) begin
    if (text_wr_ena) begin
      mem[text_wr_addr]  <= text_wr_data;
      hits[text_wr_addr] <= hits[text_wr_addr] + 1;
      wr_cnt             <= wr_cnt + 1;
      if (text_wr_addr >= 13'd1200) bad_addr <= bad_addr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic put(input logic [7:0] b);
    wait_ready();
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_wr_addr(input logic [12:0] a);
    int n = 0;
    while (!(text_wr_ena && text_wr_addr == a) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(text_wr_ena && text_wr_addr == a)) chk("wr_addr_timeout", {19'd0, text_wr_addr}, {19'd0, a});
  endtask

  initial begin
    int bad;
    int snap;
    for (int i = 0; i < 8192; i++) begin
      mem[i]  = 8'h00;
      hits[i] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wr_ena",   {31'd0, text_wr_ena}, 32'd0);
    chk("rst_wr_data",  {24'd0, text_wr_data}, 32'd0);
    chk("rst_wr_addr",  {19'd0, text_wr_addr}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_cursor",   {21'd0, cursor_row, cursor_col}, 32'd0);

    // 1: 'A','B' back-to-back
    put(8'h41);
    chk("t1_a_wr", {text_wr_ena, 3'd0, text_wr_addr, text_wr_data}, {1'b1, 3'd0, 13'd0, 8'h41} );
    chk("t1_a_ready", {31'd0, in_ready}, 32'd1);
    put(8'h42);
    chk("t1_b_wr", {text_wr_ena, 3'd0, text_wr_addr, text_wr_data}, {1'b1, 3'd0, 13'd1, 8'h42});
    chk("t1_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd0, 6'd2});
    @(posedge clk); #1;
    chk("t1_idle_ena", {31'd0, text_wr_ena}, 32'd0);
    chk("t1_hold_data", {19'd0, text_wr_addr, text_wr_data}, {19'd0, 13'd1, 8'h42});

    // 2: 60 'x' then row 1 clear
    do_reset();
    for (int i = 0; i < 60; i++) begin
      in_data  = 8'h78;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t2_last_wr", {text_wr_ena, 3'd0, text_wr_addr, text_wr_data}, {1'b1, 3'd0, 13'd59, 8'h78});
    chk("t2_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd1, 6'd0});
    chk("t2_stall", {30'd0, in_ready, busy}, 32'd1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!(text_wr_ena && text_wr_data == 8'h20 && text_wr_addr == 13'(60 + i) && !in_ready && busy))
        bad++;
    end
    chk("t2_clear_seq", bad, 0);
    @(posedge clk); #1;
    chk("t2_done", {30'd0, in_ready, busy}, 32'd2);
    chk("t2_done_ena", {31'd0, text_wr_ena}, 32'd0);

    // 3: fill to row 19, then advance wraps to row 0 and clears it
    for (int i = 0; i < 18 * 60; i++) put(8'h79);
    wait_ready();
    chk("t3_row19", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd19, 6'd0});
`ifdef TEXT_CTRL_CODES_EN
    put(8'h0A);
`else
    for (int i = 0; i < 60; i++) put(8'h79);
`endif
    wait_ready();
    chk("t3_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
    bad = 0;
    for (int a = 0; a < 60; a++) if (mem[a] != 8'h20) bad++;
    chk("t3_row0_cleared", bad, 0);
    chk("t3_addr_range", bad_addr, 0);

`ifdef TEXT_CTRL_CODES_EN
    // 4: BS / CR
    do_reset();
    put(8'h41);
    put(8'h08);
    chk("t4_bs_nowr", {31'd0, text_wr_ena}, 32'd0);
    chk("t4_bs_col", {26'd0, cursor_col}, 32'd0);
    put(8'h42);
    chk("t4_b_over", {text_wr_ena, 3'd0, text_wr_addr, text_wr_data}, {1'b1, 3'd0, 13'd0, 8'h42});
    put(8'h08);
    put(8'h08);
    chk("t4_bs_col0", {text_wr_ena, 20'd0, cursor_row, cursor_col}, 32'd0);
    put(8'h51);
    put(8'h0D);
    chk("t4_cr", {text_wr_ena, 20'd0, cursor_row, cursor_col}, 32'd0);

    // 5: form feed mid-screen
    put(8'h0A);
    put(8'h6D);
    put(8'h6E);
    chk("t5_mid", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd1, 6'd2});
    for (int a = 0; a < 1200; a++) hsnap[a] = hits[a];
    snap = wr_cnt;
    put(8'h0C);
    chk("t5_home", {20'd0, busy, cursor_row, cursor_col}, {20'd0, 1'b1, 5'd0, 6'd0});
    wait_ready();
    chk("t5_wr_count", wr_cnt - snap, 1200);
    bad = 0;
    for (int a = 0; a < 1200; a++) if (mem[a] != 8'h20 || hits[a] - hsnap[a] != 1) bad++;
    chk("t5_all_cleared", bad, 0);
    chk("t5_addr_range", bad_addr, 0);
    put(8'h7A);
    chk("t5_z", {text_wr_ena, 3'd0, text_wr_addr, text_wr_data}, {1'b1, 3'd0, 13'd0, 8'h7A});

    // 6: reset during full clear
    put(8'h0C);
    wait_wr_addr(13'd500);
    reset_n = 1'b0;
    #1;
    chk("t6_abort_ena", {31'd0, text_wr_ena}, 32'd0);
    snap = wr_cnt;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    chk("t6_ready", {30'd0, in_ready, busy}, 32'd2);
    chk("t6_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("t6_no_more_wr", wr_cnt - snap, 0);
`else
    // 6: reset during line clear, then control bytes as glyphs
    do_reset();
    for (int i = 0; i < 60; i++) put(8'h61);
    wait_wr_addr(13'd90);
    reset_n = 1'b0;
    #1;
    chk("t6_abort_ena", {31'd0, text_wr_ena}, 32'd0);
    snap = wr_cnt;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    chk("t6_ready", {30'd0, in_ready, busy}, 32'd2);
    chk("t6_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("t6_no_more_wr", wr_cnt - snap, 0);
    put(8'h0A);
    chk("t6_lf_glyph", {text_wr_ena, 3'd0, text_wr_addr, text_wr_data}, {1'b1, 3'd0, 13'd0, 8'h0A});
    put(8'h08);
    chk("t6_bs_glyph", {text_wr_ena, 3'd0, text_wr_addr, text_wr_data}, {1'b1, 3'd0, 13'd1, 8'h08});
    chk("t6_cursor2", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd0, 6'd2});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
